// File: rtl/alu_operand_mux_if.sv
// Operand-select bus for alu_operand_mux: candidate operands, select and qualifier in,
// selected value plus registered/debug observations out. Parity signals exist only under
// ALU_OPERAND_MUX_PARITY_EN.
interface alu_operand_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             in_valid;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             out_valid;
  logic             zero;
  logic [CNT_W-1:0] sel_a_cnt;
`ifdef ALU_OPERAND_MUX_PARITY_EN
  logic             parity;
  logic             parity_c;

  modport master (
    output a, b, s, in_valid,
    input  c, c_q, out_valid, zero, sel_a_cnt, parity, parity_c
  );

  modport slave (
    input  a, b, s, in_valid,
    output c, c_q, out_valid, zero, sel_a_cnt, parity, parity_c
  );
`else
  modport master (
    output a, b, s, in_valid,
    input  c, c_q, out_valid, zero, sel_a_cnt
  );

  modport slave (
    input  a, b, s, in_valid,
    output c, c_q, out_valid, zero, sel_a_cnt
  );
`endif
endinterface

// File: rtl/alu_operand_mux.sv
// Second-operand 2:1 selector for the single-cycle ALU, with a registered debug copy,
// zero flag and saturating select-a counter. Optional parity: ALU_OPERAND_MUX_PARITY_EN.
module alu_operand_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_operand_mux_if.slave bus
);

  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // An unknown select falls into the else branch, so it resolves to b.
  always_comb begin
    c_d = bus.b;
    if (bus.s == 1'b1) begin
      c_d = bus.a;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && bus.s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= bus.in_valid;
      cnt_q   <= cnt_d;
      if (bus.in_valid) begin
        data_q <= c_d;
      end
    end
  end

  assign bus.c         = c_d;
  assign bus.zero      = (c_d == '0);
  assign bus.c_q       = data_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_a_cnt = cnt_q;

`ifdef ALU_OPERAND_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (bus.in_valid) begin
      parity_q <= ^c_d;
    end
  end

  assign bus.parity   = parity_q;
  assign bus.parity_c = ^c_d;
`endif

endmodule

// File: tb/tb_alu_operand_mux.sv
// Self-checking bench for alu_operand_mux: vector table, directed sequences and randomized
// stimulus against a behavioural model. Two instances cover CNT_W=16 and CNT_W=4.
module tb_alu_operand_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        s;
  logic        in_valid;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model of the registered state
  logic [31:0] m_cq;
  logic        m_valid;
  int          m_cnt;
  int          m_cnt4;

  alu_operand_mux_if #(.WIDTH(32), .CNT_W(16)) bus ();
  alu_operand_mux_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  assign bus.a         = a;
  assign bus.b         = b;
  assign bus.s         = s;
  assign bus.in_valid  = in_valid;
  assign bus4.a        = a;
  assign bus4.b        = b;
  assign bus4.s        = s;
  assign bus4.in_valid = in_valid;

  alu_operand_mux #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_operand_mux #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_c;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] exp_c;
    exp_c = s ? a : b;
    chk({tag, " c"}, 64'(bus.c), 64'(exp_c));
    chk({tag, " zero"}, 64'(bus.zero), 64'(exp_c == 32'd0));
    chk({tag, " c4"}, 64'(bus4.c), 64'(exp_c));
`ifdef ALU_OPERAND_MUX_PARITY_EN
    chk({tag, " parity_c"}, 64'(bus.parity_c), 64'(^exp_c));
`endif
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " c_q"}, 64'(bus.c_q), 64'(m_cq));
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    chk({tag, " sel_a_cnt"}, 64'(bus.sel_a_cnt), 64'(m_cnt));
    chk({tag, " sel_a_cnt4"}, 64'(bus4.sel_a_cnt), 64'(m_cnt4));
`ifdef ALU_OPERAND_MUX_PARITY_EN
    chk({tag, " parity"}, 64'(bus.parity), 64'(^m_cq));
`endif
  endtask

  // Advance the model with the inputs present at the coming edge, then cross it.
  task automatic tick();
    if (reset) begin
      m_cq    = '0;
      m_valid = 1'b0;
      m_cnt   = 0;
      m_cnt4  = 0;
    end else if (in_valid) begin
      m_cq    = s ? a : b;
      m_valid = 1'b1;
      if (s) begin
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
      end
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h1234_5678, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{32'h5A5A_A5A5, 32'h5A5A_A5A5, 1'b1, 32'h5A5A_A5A5, 1'b0};
    vecs[7] = '{32'h5A5A_A5A5, 32'h5A5A_A5A5, 1'b0, 32'h5A5A_A5A5, 1'b0};
    vecs[8] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[9] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

    // Reset for two cycles with in_valid high; c keeps following s.
    reset    = 1'b1;
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h8765_4321;
    s        = 1'b1;
    tick();
    tick();
    check_regs("reset");
    chk("reset c s1", 64'(bus.c), 64'h1234_5678);
    s = 1'b0;
    #1;
    chk("reset c s0", 64'(bus.c), 64'h8765_4321);

    // Combinational table, applied while reset holds the registers cleared.
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      s = vecs[i].s;
      #1;
      chk($sformatf("vec%0d c", i), 64'(bus.c), 64'(vecs[i].exp_c));
      chk($sformatf("vec%0d zero", i), 64'(bus.zero), 64'(vecs[i].exp_zero));
    end
    check_regs("post-table");

    @(posedge clk);
    #1;

    // First capture, then hold with in_valid low.
    reset    = 1'b0;
    in_valid = 1'b1;
    s        = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h8765_4321;
    tick();
    check_regs("capture");
    chk("capture c_q const", 64'(bus.c_q), 64'h1234_5678);
    chk("capture cnt const", 64'(bus.sel_a_cnt), 64'd1);
    in_valid = 1'b0;
    a        = 32'hCAFE_0000;
    tick();
    check_regs("hold");
    chk("hold c_q const", 64'(bus.c_q), 64'h1234_5678);

    // Parity test-plan values through b.
    in_valid = 1'b1;
    s        = 1'b0;
    b        = 32'h0000_0007;
    tick();
    check_regs("par7");
    b = 32'h0000_0003;
    tick();
    check_regs("par3");

    // Saturation of the 4-bit counter.
    s = 1'b1;
    a = 32'h0000_00A5;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    check_regs("sat");
    chk("sat cnt4 const", 64'(bus4.sel_a_cnt), 64'd15);

    // Reset mid-operation with a simultaneous valid.
    reset = 1'b1;
    tick();
    check_regs("midreset");
    reset = 1'b0;

    // Randomized stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = 32'd0;
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      s        = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 40) == 0);
      #1;
      check_comb($sformatf("rnd%0d", i));
      tick();
      check_regs($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
